// File: rtl/alu32_vector_checker.sv
// alu32_vector_checker: drives stored operand vectors into a 32-bit add/sub ALU and scores its responses.
// Define ALU_CHK_CARRY_EN to include the carry flag in pass/fail and fail_mask[2].
module alu32_vector_checker #(
    parameter int DEPTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vec_we,
    input  logic [$clog2(DEPTH)-1:0] vec_addr,
    input  logic                     vec_sub_add,
    input  logic [31:0]              vec_a,
    input  logic [31:0]              vec_b,
    input  logic [31:0]              vec_exp_result,
    input  logic [2:0]               vec_exp_flags,
    input  logic [$clog2(DEPTH):0]   num_vec,
    input  logic                     start,
    output logic                     alu_sub_add,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    input  logic [31:0]              alu_result,
    input  logic                     alu_carry,
    input  logic                     alu_zero,
    input  logic                     alu_overflow,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   pass_count,
    output logic [$clog2(DEPTH):0]   fail_count,
    output logic                     first_fail_valid,
    output logic [$clog2(DEPTH)-1:0] first_fail_idx,
    output logic [3:0]               fail_mask
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

    typedef struct packed {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    state_t          state, state_nxt;
    vec_t            mem [DEPTH];
    vec_t            cur;
    logic [AW-1:0]   idx;
    logic [CW-1:0]   nv;
    logic [CW-1:0]   nv_clamp;
    logic [SW-1:0]   wcnt;
    logic [3:0]      mism;
    logic            last;

    assign cur      = mem[idx];
    assign nv_clamp = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
    assign last     = ({1'b0, idx} + CW'(1)) == nv;
    assign busy     = (state == DRIVE) || (state == WAIT) || (state == CHECK);
    assign done     = state == DONE;

    assign mism[3] = alu_result != cur.r;
    assign mism[1] = alu_zero != cur.f[1];
    assign mism[0] = alu_overflow != cur.f[0];
`ifdef ALU_CHK_CARRY_EN
    assign mism[2] = alu_carry != cur.f[2];
`else
    logic unused_carry;
    assign mism[2]      = 1'b0;
    assign unused_carry = alu_carry ^ cur.f[2];
`endif

    // Buffer is deliberately unreset; writes land only while idle so a run never sees a torn entry.
    always_ff @(posedge clk)
        if (vec_we && state == IDLE)
            mem[vec_addr] <= {vec_sub_add, vec_a, vec_b, vec_exp_result, vec_exp_flags};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? ((num_vec == '0) ? DONE : DRIVE) : IDLE;
            DRIVE:   state_nxt = WAIT;
            WAIT:    state_nxt = (wcnt == SW'(1)) ? CHECK : WAIT;
            CHECK:   state_nxt = last ? DONE : DRIVE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            alu_sub_add      <= 1'b0;
            alu_a            <= '0;
            alu_b            <= '0;
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            fail_mask        <= '0;
            idx              <= '0;
            nv               <= '0;
            wcnt             <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    nv               <= nv_clamp;
                    idx              <= '0;
                    pass_count       <= '0;
                    fail_count       <= '0;
                    first_fail_valid <= 1'b0;
                    first_fail_idx   <= '0;
                    fail_mask        <= '0;
                end
                DRIVE: begin
                    alu_sub_add <= cur.sub;
                    alu_a       <= cur.a;
                    alu_b       <= cur.b;
                    wcnt        <= SW'(SETTLE);
                end
                WAIT: wcnt <= wcnt - SW'(1);
                CHECK: begin
                    if (|mism) begin
                        fail_count <= fail_count + CW'(1);
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_idx   <= idx;
                            fail_mask        <= mism;
                        end
                    end else
                        pass_count <= pass_count + CW'(1);
                    if (!last)
                        idx <= idx + AW'(1);
                end
                default: ;
            endcase
        end
endmodule

// File: doc/alu32_vector_checker.md
# alu32_vector_checker

Sequential stimulus/response engine for the 32-bit add/sub ALU: sits on the ALU's operand side, drives `sub_add`, `a` and `b`, samples `result`, `carry`, `zero` and `overflow`, and compares them against stored expected values. It holds a loadable vector buffer, steps through a run under an FSM, and reports pass/fail counts plus the first failing index. The block turns the per-case ALU test wrappers into one self-checking block for board or simulation bring-up.

## Interface
- `DEPTH`, 8: vector buffer entries (power of two, 2..16).
- `SETTLE`, 1: wait cycles between driving operands and sampling ALU outputs (≥1).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `vec_we` in 1: write one buffer entry this cycle.
- `vec_addr` in log2(DEPTH): entry index.
- `vec_sub_add` in 1: stored op, 0 = add, 1 = sub.
- `vec_a`, `vec_b` in 32 each: stored operands, two's complement.
- `vec_exp_result` in 32: expected result.
- `vec_exp_flags` in 3: expected {carry, zero, overflow}.
- `num_vec` in log2(DEPTH)+1: vectors to run, 0..DEPTH, sampled on `start`.
- `start` in 1: begin a run.
- `alu_sub_add` out 1, `alu_a` out 32, `alu_b` out 32: ALU operand drive.
- `alu_result` in 32, `alu_carry` in 1, `alu_zero` in 1, `alu_overflow` in 1: ALU responses.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at run end.
- `pass_count`, `fail_count` out log2(DEPTH)+1 each.
- `first_fail_valid` out 1, `first_fail_idx` out log2(DEPTH): index of the first failing vector.
- `fail_mask` out 4: {result, carry, zero, overflow} mismatch bits of the first failure.

## Operation
- States: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE: `start`=1 latches `num_vec`, clears the counters, `first_fail_*` and `fail_mask`, and sets idx=0.
  - `num_vec`=0 goes to DONE.
  - Otherwise goes to DRIVE.
- DRIVE: registers entry[idx] onto `alu_*`, loads the wait counter with SETTLE, goes to WAIT.
- WAIT: decrements the counter; at 1 goes to CHECK.
- CHECK: compares the sampled ALU outputs with entry[idx].
  - All fields equal: `pass_count`++.
  - Otherwise: `fail_count`++. On the first failure only, capture `first_fail_idx`=idx, `first_fail_valid`=1 and `fail_mask`.
  - idx==num_vec-1 goes to DONE. Otherwise idx++ and go to DRIVE.
- DONE: `done`=1 for one cycle, then IDLE. Results hold until the next accepted `start`.
- `busy`=1 in DRIVE, WAIT and CHECK.
- `alu_*` hold their last value in IDLE and DONE.
- Buffer writes are accepted only in IDLE.
  - `vec_we` while not IDLE is ignored.
  - `vec_we` and `start` in the same IDLE cycle: the write completes first, and the run sees the new entry.
- `start` while not IDLE is ignored.
- `num_vec`>DEPTH is clamped to DEPTH.
- Counters are log2(DEPTH)+1 bits wide, so they cannot wrap within a run.
- Invariant at DONE: pass_count + fail_count == num_vec.

## Timing
- Reset values: state IDLE, `alu_sub_add`=0, `alu_a`=0, `alu_b`=0, `busy`=0, `done`=0, both counts 0, `first_fail_valid`=0, `first_fail_idx`=0, `fail_mask`=0.
- The buffer is not reset. Contents are undefined until written.
- Reset asserted mid-run: the run is aborted immediately to reset values, with no `done` pulse.
- `start` sampled in cycle T:
  - DRIVE in T+1.
  - Operands visible at `alu_*` in T+2.
  - CHECK in T+1+1+SETTLE.
  - Each vector costs 2+SETTLE cycles.
- `done` occurs one cycle after the last CHECK, at T + 1 + num_vec·(2+SETTLE).
- `num_vec`=0: `done` at T+1.
- The ALU is combinational, and its outputs are sampled at the end of the CHECK cycle.

## Configuration
- `ALU_CHK_CARRY_EN` defined: the carry mismatch contributes to pass/fail and sets `fail_mask[2]`.
- `ALU_CHK_CARRY_EN` undefined: carry is not compared, and `fail_mask[2]` is tied to 0. Result, zero and overflow checking are unchanged.

## Test plan
- Single-vector pass: load entry0 add, a=0x1234_5678, b=0x2000_0000, expected 0x3234_5678, flags 000 (ALU model matching), `num_vec`=1, SETTLE=1. Required: `done` 4 cycles after `start`, pass=1, fail=0, `first_fail_valid`=0.
- Injected failure: entry2 expected result off by 1 among 4 vectors. Required: pass=3, fail=1, `first_fail_idx`=2, `fail_mask`=1000.
- Subtract/zero: entry sub, a=b=0x7FFF_FFFF, expected 0, zero=1. Required: pass. Then expected zero=0 gives `fail_mask`=0010.
- Carry gating: expected carry wrong only. With `ALU_CHK_CARRY_EN`: fail, mask 0100. Without the macro: pass.
- Boundaries:
  - `num_vec`=0 gives `done` at T+1 with counts 0.
  - `num_vec`=DEPTH runs all entries.
  - `start` and `vec_we` while busy are ignored, with the buffer and counts unchanged.
- Reset mid-run: assert `rst_n`=0 during WAIT of vector 1. Required: all outputs at reset values with no `done`. A subsequent run gives correct counts.
